// File: rtl/tile_click_ctrl_if.sv
// Board-side bus of the click controller: the mine-map query port and the
// renderer tile-state read port.
interface tile_click_ctrl_if;
  logic [4:0] mine_rd_x;
  logic [4:0] mine_rd_y;
  logic       mine_rd_data;
  logic [4:0] rd_x;
  logic [4:0] rd_y;
  logic [1:0] rd_state;

  // Controller side.
  modport master (
    output mine_rd_x,
    output mine_rd_y,
    output rd_state,
    input  mine_rd_data,
    input  rd_x,
    input  rd_y
  );

  // Mine map / renderer side.
  modport slave (
    input  mine_rd_x,
    input  mine_rd_y,
    input  rd_state,
    output mine_rd_data,
    output rd_x,
    output rd_y
  );
endinterface

// File: rtl/tile_click_ctrl.sv
// Minesweeper click controller: turns bomb/flag button edges into tile-state
// updates, tracks flag/reveal counters and the sticky win/lose status, and
// clears the board one address per cycle on reset or new game.
module tile_click_ctrl #(
  parameter int unsigned GRID_MAX = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     new_game,
  input  logic [4:0]               board_tiles,
  input  logic [8:0]               mine_count,
  input  logic                     bomb,
  input  logic                     flag,
  input  logic [4:0]               button_index_x,
  input  logic [4:0]               button_index_y,
  tile_click_ctrl_if.master        bus,
  output logic                     busy,
  output logic                     explode,
  output logic                     game_lost,
  output logic                     game_won,
  output logic [8:0]               flags_cnt,
  output logic [8:0]               revealed_cnt
);

  localparam int unsigned NumTiles = GRID_MAX * GRID_MAX;
  localparam int unsigned AddrW    = $clog2(NumTiles);
  localparam logic [AddrW-1:0] LastAddr = AddrW'(NumTiles - 1);

  localparam logic [1:0] TileHidden = 2'b00;
  localparam logic [1:0] TileFlag   = 2'b01;
  localparam logic [1:0] TileOpen   = 2'b10;
  localparam logic [1:0] TileMine   = 2'b11;

  typedef enum logic [1:0] {StClear, StIdle, StFetch, StEval} state_e;

  // 1-based (x,y) to linear board address.
  function automatic logic [AddrW-1:0] tile_addr(input logic [4:0] x, input logic [4:0] y);
    return AddrW'((32'(y) - 32'd1) * GRID_MAX + 32'(x) - 32'd1);
  endfunction

  logic [1:0] mem [NumTiles];

  state_e           state_q, state_d;
  logic [AddrW-1:0] clr_q, clr_d;
  logic [8:0]       flags_q, flags_d;
  logic [8:0]       rev_q, rev_d;
  logic             lost_q, lost_d;
  logic             won_q, won_d;
  logic             explode_q, explode_d;
  logic             bomb_q, flag_q;
  logic [4:0]       mine_rd_x_q, mine_rd_y_q;
  logic             ev_bomb_q;
  logic [AddrW-1:0] ev_addr_q;
  logic [1:0]       tile_q;
  logic [1:0]       rd_state_q;

  logic             bomb_rise, flag_rise, in_range, ev_accept;
  logic             mem_we;
  logic [AddrW-1:0] mem_waddr;
  logic [1:0]       mem_wdata;
  logic [8:0]       rev_inc;
  logic [11:0]      safe_target;

  assign bomb_rise = bomb & ~bomb_q;
  assign flag_rise = flag & ~flag_q;
  assign in_range  = (button_index_x != 5'd0) && (button_index_y != 5'd0) &&
                     (button_index_x <= board_tiles) && (button_index_y <= board_tiles);
  assign ev_accept = (bomb_rise | flag_rise) && enable && !new_game && (state_q == StIdle) &&
                     !lost_q && !won_q && in_range;

  assign rev_inc     = rev_q + 9'd1;
  // Wide enough for 31*31 so the safe-tile target never truncates.
  assign safe_target = {7'd0, board_tiles} * {7'd0, board_tiles} - {3'd0, mine_count};

  // Next-state, board write port and counter/status updates.
  always_comb begin
    state_d   = state_q;
    clr_d     = clr_q;
    flags_d   = flags_q;
    rev_d     = rev_q;
    lost_d    = lost_q;
    won_d     = won_q;
    explode_d = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = clr_q;
    mem_wdata = TileHidden;
    if (new_game) begin
      // Abort anything in flight; the EVAL write below is skipped.
      state_d = StClear;
      clr_d   = '0;
      flags_d = '0;
      rev_d   = '0;
      lost_d  = 1'b0;
      won_d   = 1'b0;
    end else begin
      case (state_q)
        StClear: begin
          mem_we = 1'b1;
          clr_d  = clr_q + 1'b1;
          if (clr_q == LastAddr) state_d = StIdle;
        end
        StIdle: begin
          if (ev_accept) state_d = StFetch;
        end
        StFetch: begin
          state_d = StEval;
        end
        StEval: begin
          state_d   = StIdle;
          mem_waddr = ev_addr_q;
          if (ev_bomb_q) begin
            if (tile_q == TileHidden) begin
              mem_we = 1'b1;
              if (bus.mine_rd_data) begin
                mem_wdata = TileMine;
                explode_d = 1'b1;
                lost_d    = 1'b1;
              end else begin
                mem_wdata = TileOpen;
                rev_d     = rev_inc;
                if ({3'd0, rev_inc} == safe_target) won_d = 1'b1;
              end
            end
          end else begin
            case (tile_q)
              TileHidden: begin
                mem_we    = 1'b1;
                mem_wdata = TileFlag;
                flags_d   = flags_q + 9'd1;
              end
              TileFlag: begin
                mem_we    = 1'b1;
                mem_wdata = TileHidden;
                flags_d   = flags_q - 9'd1;
              end
              default: ;
            endcase
          end
        end
        default: state_d = StClear;
      endcase
    end
    mem_we = mem_we & ~rst;
  end

  // Control state, counters, edge detectors and event capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StClear;
      clr_q       <= '0;
      flags_q     <= '0;
      rev_q       <= '0;
      lost_q      <= 1'b0;
      won_q       <= 1'b0;
      explode_q   <= 1'b0;
      bomb_q      <= 1'b0;
      flag_q      <= 1'b0;
      mine_rd_x_q <= '0;
      mine_rd_y_q <= '0;
      ev_bomb_q   <= 1'b0;
      ev_addr_q   <= '0;
      tile_q      <= TileHidden;
    end else begin
      state_q   <= state_d;
      clr_q     <= clr_d;
      flags_q   <= flags_d;
      rev_q     <= rev_d;
      lost_q    <= lost_d;
      won_q     <= won_d;
      explode_q <= explode_d;
      bomb_q    <= bomb;
      flag_q    <= flag;
      if (ev_accept) begin
        // Bomb wins when both edges land together.
        ev_bomb_q   <= bomb_rise;
        ev_addr_q   <= tile_addr(button_index_x, button_index_y);
        mine_rd_x_q <= button_index_x;
        mine_rd_y_q <= button_index_y;
      end
      if (state_q == StFetch) tile_q <= mem[ev_addr_q];
    end
  end

  // Board state write port.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Renderer read port; the board is logically all-hidden while clearing.
  always_ff @(posedge clk) begin
    if (rst || (state_q == StClear)) begin
      rd_state_q <= TileHidden;
    end else begin
      rd_state_q <= mem[tile_addr(bus.rd_x, bus.rd_y)];
    end
  end

  assign bus.mine_rd_x = mine_rd_x_q;
  assign bus.mine_rd_y = mine_rd_y_q;
  assign bus.rd_state  = rd_state_q;
  assign busy          = (state_q != StIdle);
  assign explode       = explode_q;
  assign game_lost     = lost_q;
  assign game_won      = won_q;
  assign flags_cnt     = flags_q;
  assign revealed_cnt  = rev_q;

endmodule

// File: tb/tb_tile_click_ctrl.sv
// Directed bench for tile_click_ctrl with a registered mine-map model.
module tb_tile_click_ctrl;

  logic       clk = 1'b0;
  logic       rst, enable, new_game, bomb, flag;
  logic [4:0] board_tiles, bx, by;
  logic [8:0] mine_count;
  logic       busy, explode, game_lost, game_won;
  logic [8:0] flags_cnt, revealed_cnt;
  logic       mines [256];
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  tile_click_ctrl_if bus ();

  tile_click_ctrl #(.GRID_MAX(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .new_game       (new_game),
    .board_tiles    (board_tiles),
    .mine_count     (mine_count),
    .bomb           (bomb),
    .flag           (flag),
    .button_index_x (bx),
    .button_index_y (by),
    .bus            (bus),
    .busy           (busy),
    .explode        (explode),
    .game_lost      (game_lost),
    .game_won       (game_won),
    .flags_cnt      (flags_cnt),
    .revealed_cnt   (revealed_cnt)
  );

  // Mine map: data valid one cycle after the query address.
  always @(posedge clk) begin
    int idx;
    idx = (int'(bus.mine_rd_y) - 1) * 16 + int'(bus.mine_rd_x) - 1;
    if (bus.mine_rd_x != 5'd0 && bus.mine_rd_y != 5'd0 && idx < 256) begin
      bus.mine_rd_data <= mines[idx];
    end else begin
      bus.mine_rd_data <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic read_tile(input int x, input int y, output logic [1:0] st);
    bus.rd_x = 5'(x);
    bus.rd_y = 5'(y);
    @(negedge clk);
    st = bus.rd_state;
  endtask

  // Press for 'hold' cycles, then release; counts busy cycles seen.
  task automatic click(input bit b, input bit f, input int x, input int y, input int hold,
                       output int busy_cyc);
    bx = 5'(x);
    by = 5'(y);
    bomb = b;
    flag = f;
    busy_cyc = 0;
    for (int i = 0; i < hold + 8; i++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (i == hold - 1) begin
        bomb = 1'b0;
        flag = 1'b0;
      end
    end
  endtask

  task automatic wait_clear(output int cyc);
    cyc = 0;
    while (busy && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
  endtask

  initial begin
    int         cyc, bc, bad;
    logic [1:0] st;
    rst = 1'b1; enable = 1'b0; new_game = 1'b0; bomb = 1'b0; flag = 1'b0;
    board_tiles = 5'd8; mine_count = 9'd10; bx = '0; by = '0;
    bus.rd_x = 5'd1; bus.rd_y = 5'd1;
    for (int i = 0; i < 256; i++) mines[i] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("rst_busy", busy, 1);
    check("rst_explode", explode, 0);
    check("rst_lost", game_lost, 0);
    check("rst_won", game_won, 0);
    check("rst_flags", flags_cnt, 0);
    check("rst_revealed", revealed_cnt, 0);
    check("rst_mine_rd_x", bus.mine_rd_x, 0);
    check("rst_mine_rd_y", bus.mine_rd_y, 0);
    check("rst_rd_state", bus.rd_state, 0);

    wait_clear(cyc);
    check("clear_cycles", cyc, 256);
    check("clear_done_busy", busy, 0);
    bad = 0;
    for (int y = 1; y <= 16; y++) begin
      for (int x = 1; x <= 16; x++) begin
        read_tile(x, y, st);
        if (st !== 2'b00) bad++;
      end
    end
    check("board_all_hidden", bad, 0);

    enable = 1'b1;
    mines[(5 - 1) * 16 + (5 - 1)] = 1'b1;

    click(1'b0, 1'b1, 3, 4, 1, bc);
    check("flag_busy_cycles", bc, 2);
    read_tile(3, 4, st);
    check("flag_state", st, 1);
    check("flag_cnt_1", flags_cnt, 1);
    check("mine_rd_x_hold", bus.mine_rd_x, 3);
    check("mine_rd_y_hold", bus.mine_rd_y, 4);

    click(1'b0, 1'b1, 3, 4, 1, bc);
    read_tile(3, 4, st);
    check("unflag_state", st, 0);
    check("unflag_cnt", flags_cnt, 0);

    click(1'b1, 1'b0, 2, 2, 10, bc);
    check("held_bomb_busy", bc, 2);
    check("held_bomb_revealed", revealed_cnt, 1);
    read_tile(2, 2, st);
    check("held_bomb_state", st, 2);

    click(1'b0, 1'b1, 3, 4, 1, bc);
    click(1'b1, 1'b0, 3, 4, 1, bc);
    read_tile(3, 4, st);
    check("bomb_on_flag_state", st, 1);
    check("bomb_on_flag_rev", revealed_cnt, 1);
    check("bomb_on_flag_flags", flags_cnt, 1);

    // Mine hit with cycle-exact explode check.
    bx = 5'd5; by = 5'd5; bomb = 1'b1;
    @(negedge clk);
    check("mine_n1_busy", busy, 1);
    check("mine_n1_explode", explode, 0);
    check("mine_n1_rd_x", bus.mine_rd_x, 5);
    @(negedge clk);
    check("mine_n2_busy", busy, 1);
    check("mine_n2_explode", explode, 0);
    @(negedge clk);
    check("mine_n3_explode", explode, 1);
    check("mine_n3_lost", game_lost, 1);
    bomb = 1'b0;
    @(negedge clk);
    check("mine_n4_explode", explode, 0);
    read_tile(5, 5, st);
    check("mine_state", st, 3);

    click(1'b0, 1'b1, 6, 6, 1, bc);
    check("lost_ignore_busy", bc, 0);
    read_tile(6, 6, st);
    check("lost_ignore_state", st, 0);
    check("lost_ignore_flags", flags_cnt, 1);

    pulse_new_game();
    wait_clear(cyc);
    check("ng_clear_cycles", cyc, 256);
    check("ng_flags", flags_cnt, 0);
    check("ng_revealed", revealed_cnt, 0);
    check("ng_lost", game_lost, 0);

    // 2x2 board, one mine at (2,2).
    board_tiles = 5'd2; mine_count = 9'd1;
    mines[(5 - 1) * 16 + (5 - 1)] = 1'b0;
    mines[(2 - 1) * 16 + (2 - 1)] = 1'b1;
    click(1'b1, 1'b0, 3, 1, 1, bc);
    check("oob_x_busy", bc, 0);
    click(1'b1, 1'b0, 0, 2, 1, bc);
    check("zero_x_busy", bc, 0);
    check("oob_revealed", revealed_cnt, 0);
    click(1'b1, 1'b0, 1, 1, 1, bc);
    check("win_rev1", revealed_cnt, 1);
    check("win_not_yet1", game_won, 0);
    click(1'b1, 1'b0, 2, 1, 1, bc);
    check("win_rev2", revealed_cnt, 2);
    check("win_not_yet2", game_won, 0);
    click(1'b1, 1'b0, 1, 2, 1, bc);
    check("win_rev3", revealed_cnt, 3);
    check("win_set", game_won, 1);
    click(1'b1, 1'b0, 2, 2, 1, bc);
    check("won_ignore_busy", bc, 0);
    check("won_ignore_lost", game_lost, 0);

    pulse_new_game();
    wait_clear(cyc);
    check("ng2_won", game_won, 0);
    board_tiles = 5'd8; mine_count = 9'd10;

    click(1'b1, 1'b1, 4, 4, 1, bc);
    check("both_busy", bc, 2);
    check("both_revealed", revealed_cnt, 1);
    check("both_flags", flags_cnt, 0);
    read_tile(4, 4, st);
    check("both_state", st, 2);

    // new_game while in FETCH.
    bx = 5'd6; by = 5'd6; flag = 1'b1;
    @(negedge clk);
    check("abort_in_fetch_busy", busy, 1);
    flag = 1'b0;
    pulse_new_game();
    check("abort_clear_busy", busy, 1);
    wait_clear(cyc);
    check("abort_clear_cycles", cyc, 256);
    check("abort_flags", flags_cnt, 0);
    check("abort_revealed", revealed_cnt, 0);
    read_tile(6, 6, st);
    check("abort_no_write", st, 0);
    read_tile(4, 4, st);
    check("abort_cleared_tile", st, 0);

    // rst mid-clear restarts from address 0.
    pulse_new_game();
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_clear(cyc);
    check("rst_restart_cycles", cyc, 256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tile_click_ctrl.md
TILE_CLICK_CTRL -- requirements
Module: tile_click_ctrl

Interface
REQ-001 Parameter: GRID_MAX, 16, max tiles per board side; state array holds GRID_MAX*GRID_MAX entries, address = (y-1)*GRID_MAX + (x-1).
REQ-002 clk  in  1  system clock; all logic on posedge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 enable  in  1  game active; low = click events ignored.
REQ-005 new_game  in  1  single-cycle pulse; clears board and counters.
REQ-006 board_tiles  in  5  tiles per side for current level, 2..GRID_MAX, stable during a game.
REQ-007 mine_count  in  9  mines on current board, stable during a game.
REQ-008 bomb  in  1  left-click level (reveal request), registered, held while button held.
REQ-009 flag  in  1  right-click level (flag toggle request).
REQ-010 button_index_x / button_index_y  in  5 each  1-based tile index; 0 = cursor off board.
REQ-011 mine_rd_x / mine_rd_y  out  5 each  1-based tile query to mine map.
REQ-012 mine_rd_data  in  1  mine present at queried tile; valid 1 cycle after address.
REQ-013 rd_x / rd_y  in  5 each  renderer tile read address, 1-based.
REQ-014 rd_state  out  2  tile state at rd_x/rd_y, 1-cycle latency: 00 hidden, 01 flagged, 10 revealed, 11 revealed-mine.
REQ-015 busy  out  1  high while clearing or processing an event.
REQ-016 explode  out  1  1-cycle pulse on revealing a mine.
REQ-017 game_lost / game_won  out  1 each  sticky status.
REQ-018 flags_cnt / revealed_cnt  out  9 each  tiles currently flagged / safely revealed.

Function
REQ-019 Rising edge of bomb (bomb & !bomb_q) or flag (flag & !flag_q) SHALL form an event; held levels SHALL NOT repeat events.
REQ-020 Bomb and flag edges in same cycle: bomb wins, flag discarded.
REQ-021 Events SHALL be discarded when enable=0, busy=1, game_lost=1, game_won=1, either index = 0, or either index > board_tiles.
REQ-022 FSM states: CLEAR, IDLE, FETCH, EVAL.
REQ-023 IDLE, accepted event in cycle N: capture indices and event type; next state FETCH.
REQ-024 FETCH (N+1): drive mine_rd_x/y = captured indices; read tile state; next state EVAL.
REQ-025 EVAL (N+2): state and mine_rd_data valid; write tile state; update counters/status; next state IDLE; busy high N+1..N+2.
REQ-026 Flag on hidden -> flagged, flags_cnt+1; on flagged -> hidden, flags_cnt-1; on revealed/revealed-mine -> no change.
REQ-027 Bomb on flagged or revealed tile -> no change, no pulse.
REQ-028 Bomb on hidden, mine_rd_data=0 -> revealed, revealed_cnt+1.
REQ-029 Bomb on hidden, mine_rd_data=1 -> revealed-mine, explode=1 in cycle N+3, game_lost=1 from N+3.
REQ-030 When revealed_cnt becomes board_tiles*board_tiles - mine_count, game_won=1 from N+3 (full-width unsigned compare, no truncation).
REQ-031 mine_rd_x/y SHALL hold last captured value outside FETCH.
REQ-032 new_game pulse in any state (including FETCH/EVAL) SHALL abort in-flight event without writing, enter CLEAR.
REQ-033 CLEAR: write 00 to one address per cycle, 0..GRID_MAX*GRID_MAX-1, busy=1; then IDLE; counters, game_lost, game_won zeroed on CLEAR entry.
REQ-034 rd_state read port SHALL be independent of FSM; same-cycle write and read to one address returns old value.
REQ-035 Counters never wrap: flags_cnt decrements only from flagged tiles, increments only to hidden tiles.

Reset
REQ-036 rst SHALL enter CLEAR; busy=1, explode=0, game_lost=0, game_won=0, flags_cnt=0, revealed_cnt=0, mine_rd_x/y=0, bomb_q=flag_q=0; rd_state=00 from cycle after rst.
REQ-037 rst asserted mid-CLEAR or mid-event SHALL restart CLEAR from address 0.

Verification
REQ-038 rst, wait GRID_MAX^2 cycles -> busy=0, every rd_state=00, counters 0.
REQ-039 board_tiles=8, flag edge at (3,4) -> rd_state(3,4)=01, flags_cnt=1; second flag edge -> 00, flags_cnt=0; bomb held 10 cycles on hidden (2,2), no mine -> single reveal, revealed_cnt=1.
REQ-040 Bomb on flagged (3,4) -> state stays 01; bomb on (5,5) with mine_rd_data=1 -> explode pulse exactly N+3, rd_state=11, game_lost=1, later clicks ignored.
REQ-041 board_tiles=2, mine_count=1, reveal 3 safe tiles -> game_won=1 after third EVAL; index (3,1) or (0,2) -> ignored, busy stays 0.
REQ-042 bomb and flag edges same cycle on hidden safe tile -> revealed, flags_cnt unchanged; new_game during FETCH -> no write, CLEAR runs, counters 0.
